data_to_axi_stream: RTL and testbench
=====================================

DATA_TO_AXI_STREAM -- requirements
Module: data_to_axi_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, giving the packet and AXIS tdata width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the number of buffered entries; it is a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port write_enable  input  1  request to enqueue one packet.
REQ-006 SHALL have port data_pkt  input  DATA_WIDTH  packet payload.
REQ-007 SHALL have port tlast  input  1  marks the requested packet as end-of-frame.
REQ-008 SHALL have port tlast_interval  input  32  beats per frame; 0 disables interval framing.
REQ-009 SHALL have port M_AXIS_tvalid  output  1  AXI-Stream valid.
REQ-010 SHALL have port M_AXIS_tready  input  1  AXI-Stream ready.
REQ-011 SHALL have port M_AXIS_tdata  output  DATA_WIDTH  AXI-Stream data.
REQ-012 SHALL have port M_AXIS_tlast  output  1  AXI-Stream last.

Function
REQ-013 SHALL register write_enable and tlast for one cycle: a request in cycle N captures data_pkt sampled at the rising edge ending cycle N+1, with the tlast value from cycle N.
REQ-014 SHALL store each captured packet plus its tlast flag in an internal FIFO of FIFO_DEPTH entries.
REQ-015 SHALL silently drop a capture when the FIFO is full, unless a beat pops in the same cycle, in which case the capture is accepted.
REQ-016 SHALL present the FIFO head first-word-fall-through:
- M_AXIS_tvalid = not empty.
- M_AXIS_tdata = head payload, or 0 when empty.
REQ-017 SHALL transfer a beat only when M_AXIS_tvalid and M_AXIS_tready are both 1, popping the head that cycle.
REQ-018 SHALL hold tdata, tlast and tvalid stable while M_AXIS_tvalid=1 and M_AXIS_tready=0.
REQ-019 SHALL keep a 32-bit beat counter of beats transferred since the last tlast beat.
REQ-020 SHALL drive M_AXIS_tlast=1 when tvalid=1 and either condition holds:
- the head's stored tlast flag is set;
- tlast_interval != 0 and beat counter + 1 >= tlast_interval.
REQ-021 SHALL clear the beat counter to 0 on transfer of a tlast beat, and increment it on any other transfer.
REQ-022 SHALL, when empty and write_enable pulses once, raise M_AXIS_tvalid exactly 2 cycles after the request cycle.
REQ-023 SHALL preserve packet order and never duplicate a beat.

Reset
REQ-024 SHALL, on rst_n low, immediately:
- empty the FIFO;
- clear pointers, the pending capture and the beat counter;
- force M_AXIS_tvalid=0, M_AXIS_tlast=0 and M_AXIS_tdata=0.
REQ-025 SHALL discard any in-flight request and stored entry when reset is asserted mid-operation, and accept requests again from the first rising edge after release.

Configuration
REQ-026 SHALL, when macro DATA_TO_AXI_STREAM_DROP_COUNT_EN is defined:
- add output port dropped_count  output  32  number of captures dropped on full;
- saturate the count at 0xFFFFFFFF;
- clear the count on reset.
REQ-027 SHALL, without DATA_TO_AXI_STREAM_DROP_COUNT_EN, omit the port and its counter, with all other behaviour identical.

Structure
REQ-028 SHALL take the DATA_WIDTH default and the 32-bit counter width constant from shared package data_to_axi_stream_pkg.
REQ-029 SHALL implement storage in one sub-module, data_to_axi_stream_fifo: a synchronous FWFT FIFO carrying payload plus tlast flag, with full/empty flags and a pointer wrap bit.

Verification
REQ-030 SHALL be verified by bench scenario 1: tready=1, interval=0, write pkt 0xA5 in cycle 0 -> tvalid=1 with tdata=0xA5 in cycle 2, tlast=0.
REQ-031 SHALL be verified by bench scenario 2: interval=4, tready=1, 8 back-to-back writes -> tlast=1 on beats 4 and 8 only.
REQ-032 SHALL be verified by bench scenario 3: tready=0, 20 writes with FIFO_DEPTH=16 -> exactly 16 beats are later delivered, in order, and dropped_count=4 when the macro is defined.
REQ-033 SHALL be verified by bench scenario 4: tlast input high on the 3rd of 5 writes, interval=0 -> tlast=1 only on beat 3, with the beat counter restarting after it.
REQ-034 SHALL be verified by bench scenario 5: tready toggling 1/0 each cycle -> tdata and tlast are held whenever tready=0.
REQ-035 SHALL be verified by bench scenario 6: rst_n low while 5 entries are queued -> tvalid=0 immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/data_to_axi_stream_pkg.sv
// Shared constants for the data_to_axi_stream packet-to-AXIS bridge.
package data_to_axi_stream_pkg;

   localparam int DATA_WIDTH_DEF = 512;
   localparam int CNT_W          = 32;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/data_to_axi_stream_fifo.sv
// Synchronous first-word-fall-through FIFO carrying a payload plus a tlast flag.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module data_to_axi_stream_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             wr_last_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_last_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic             mem_last [DEPTH];

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_wr, do_rd;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A write into a full FIFO is legal when the head leaves in the same cycle.
   assign do_rd = rd_en_i & ~empty_o;
   assign do_wr = wr_en_i & (~full_o | do_rd);

   assign rd_data_o = mem_data[rd_ptr_q[AW-1:0]];
   assign rd_last_o = mem_last[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_data[wr_ptr_q[AW-1:0]] <= wr_data_i;
         mem_last[wr_ptr_q[AW-1:0]] <= wr_last_i;
      end
   end

endmodule

// File: rtl/data_to_axi_stream.sv
// Packet-to-AXI-Stream bridge: one-cycle request pipeline, FWFT buffer, interval framing.
// Define DATA_TO_AXI_STREAM_DROP_COUNT_EN to add the saturating dropped_count output.
module data_to_axi_stream
   import data_to_axi_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data_pkt,
   input  logic                  tlast,
   input  logic [31:0]           tlast_interval,
   output logic                  M_AXIS_tvalid,
   input  logic                  M_AXIS_tready,
   output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                  M_AXIS_tlast
`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
   ,
   output logic [CNT_W-1:0]      dropped_count
`endif
);

   logic                  we_q, tlast_q;
   logic                  fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_last;
   logic                  pop, interval_hit;
   cnt_t                  beat_cnt_q, beat_cnt_d;

   // Payload is sampled one edge after the request; the flag comes with the request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         tlast_q <= 1'b0;
      end else begin
         we_q    <= write_enable;
         tlast_q <= tlast;
      end
   end

   data_to_axi_stream_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (we_q),
      .wr_data_i (data_pkt),
      .wr_last_i (tlast_q),
      .rd_en_i   (pop),
      .rd_data_o (head_data),
      .rd_last_o (head_last),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign pop           = ~fifo_empty & M_AXIS_tready;
   assign M_AXIS_tvalid = ~fifo_empty;
   assign M_AXIS_tdata  = fifo_empty ? '0 : head_data;

   // Widened compare so beat_cnt + 1 cannot wrap at the counter limit.
   assign interval_hit  = (tlast_interval != 32'd0) &&
                          (({1'b0, beat_cnt_q} + 33'd1) >= {1'b0, tlast_interval});
   assign M_AXIS_tlast  = ~fifo_empty & (head_last | interval_hit);

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (pop) beat_cnt_d = M_AXIS_tlast ? '0 : beat_cnt_q + cnt_t'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_cnt_q <= '0;
      else        beat_cnt_q <= beat_cnt_d;
   end

`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
   cnt_t drop_cnt_q;
   logic drop;

   assign drop          = we_q & fifo_full & ~pop;
   assign dropped_count = drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + cnt_t'(1);
   end
`endif

endmodule

// File: tb/tb_data_to_axi_stream.sv
// Self-checking bench for data_to_axi_stream: directed scenarios plus a random phase
// against a queue-based reference model.
module tb_data_to_axi_stream;

   localparam int DW    = 512;
   localparam int DEPTH = 16;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          write_enable;
   logic [DW-1:0] data_pkt;
   logic          tlast;
   logic [31:0]   tlast_interval;
   logic          M_AXIS_tvalid;
   logic          M_AXIS_tready;
   logic [DW-1:0] M_AXIS_tdata;
   logic          M_AXIS_tlast;
`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
   logic [31:0]   dropped_count;
`endif

   data_to_axi_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .write_enable   (write_enable),
      .data_pkt       (data_pkt),
      .tlast          (tlast),
      .tlast_interval (tlast_interval),
      .M_AXIS_tvalid  (M_AXIS_tvalid),
      .M_AXIS_tready  (M_AXIS_tready),
      .M_AXIS_tdata   (M_AXIS_tdata),
      .M_AXIS_tlast   (M_AXIS_tlast)
`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
      ,
      .dropped_count  (dropped_count)
`endif
   );

   always #5 clk = ~clk;

   int            vectors = 0;
   int            miscompares = 0;

   // Reference model state
   ent_t          q[$];
   logic          prev_we = 1'b0;
   logic          prev_last = 1'b0;
   longint        beats = 0;
   longint        drops = 0;
   logic [DW-1:0] xfer_d[$];
   logic          xfer_l[$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_last();
      return (q.size() > 0) &&
             (q[0].l || (tlast_interval != 0 && beats + 1 >= longint'(tlast_interval)));
   endfunction

   task automatic check_outputs();
      logic [DW-1:0] ed;
      ed = (q.size() > 0) ? q[0].d : '0;
      chk("tvalid", M_AXIS_tvalid, (q.size() > 0) ? 1'b1 : 1'b0);
      chk("tdata", M_AXIS_tdata, ed);
      chk("tlast", M_AXIS_tlast, exp_last());
`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
      chk("dropped_count", dropped_count, (drops > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : drops[31:0]);
`endif
   endtask

   task automatic clear_model();
      q.delete();
      prev_we   = 1'b0;
      prev_last = 1'b0;
      beats     = 0;
      drops     = 0;
   endtask

   // One clock: update the model with the pre-edge inputs, then compare at the falling edge.
   task automatic tick();
      logic l;
      @(posedge clk);
      if (!rst_n) begin
         clear_model();
      end else begin
         if (q.size() > 0 && M_AXIS_tready) begin
            l = exp_last();
            xfer_d.push_back(q[0].d);
            xfer_l.push_back(l);
            beats = l ? 0 : beats + 1;
            void'(q.pop_front());
         end
         if (prev_we) begin
            if (q.size() < DEPTH) q.push_back('{d: data_pkt, l: prev_last});
            else drops++;
         end
         prev_we   = write_enable;
         prev_last = tlast;
      end
      @(negedge clk);
      check_outputs();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic do_reset();
      write_enable = 1'b0;
      tlast        = 1'b0;
      rst_n        = 1'b0;
      clear_model();
      #1;
      check_outputs();
      tick();
      rst_n = 1'b1;
      xfer_d.delete();
      xfer_l.delete();
   endtask

   initial begin
      rst_n          = 1'b1;
      write_enable   = 1'b0;
      tlast          = 1'b0;
      data_pkt       = '0;
      tlast_interval = 32'd0;
      M_AXIS_tready  = 1'b0;
      @(negedge clk);
      do_reset();

      // Scenario 1: single write reaches the output two cycles after the request
      M_AXIS_tready = 1'b1;
      tlast_interval = 0;
      write_enable = 1'b1;
      data_pkt = DW'(8'hA5);
      tick();
      write_enable = 1'b0;
      chk("s1_not_early", M_AXIS_tvalid, 1'b0);
      tick();
      chk("s1_valid", M_AXIS_tvalid, 1'b1);
      chk("s1_data", M_AXIS_tdata, DW'(8'hA5));
      chk("s1_last", M_AXIS_tlast, 1'b0);
      tick();

      // Scenario 2: interval framing every 4 beats
      do_reset();
      tlast_interval = 4;
      M_AXIS_tready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         write_enable = 1'b1;
         data_pkt = DW'(c);
         tick();
      end
      write_enable = 1'b0;
      data_pkt = DW'(8);
      for (int c = 0; c < 6; c++) tick();
      chk("s2_beats", DW'(xfer_l.size()), DW'(8));
      for (int i = 0; i < xfer_l.size(); i++)
         chk($sformatf("s2_last_%0d", i), xfer_l[i], (i % 4 == 3) ? 1'b1 : 1'b0);

      // Scenario 3: overflow with tready low, then drain
      do_reset();
      tlast_interval = 0;
      M_AXIS_tready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         write_enable = 1'b1;
         data_pkt = DW'(c);
         tick();
      end
      write_enable = 1'b0;
      data_pkt = DW'(20);
      tick();
      tick();
      M_AXIS_tready = 1'b1;
      for (int c = 0; c < 22; c++) tick();
      chk("s3_beats", DW'(xfer_d.size()), DW'(16));
      for (int i = 0; i < xfer_d.size(); i++)
         chk($sformatf("s3_order_%0d", i), xfer_d[i], DW'(i + 1));
`ifdef DATA_TO_AXI_STREAM_DROP_COUNT_EN
      chk("s3_dropped", dropped_count, 32'd4);
`endif

      // Scenario 4: explicit tlast on the 3rd of 5 writes
      do_reset();
      tlast_interval = 0;
      M_AXIS_tready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         write_enable = 1'b1;
         tlast = (c == 2);
         data_pkt = rnd_data();
         tick();
      end
      write_enable = 1'b0;
      tlast = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      chk("s4_beats", DW'(xfer_l.size()), DW'(5));
      for (int i = 0; i < xfer_l.size(); i++)
         chk($sformatf("s4_last_%0d", i), xfer_l[i], (i == 2) ? 1'b1 : 1'b0);

      // Scenario 5: tready toggling, interval framing active
      do_reset();
      tlast_interval = 3;
      for (int c = 0; c < 24; c++) begin
         write_enable = (c < 8);
         tlast = 1'b0;
         data_pkt = rnd_data();
         M_AXIS_tready = c[0];
         tick();
      end
      chk("s5_beats", DW'(xfer_l.size()), DW'(8));

      // Scenario 6: reset with 5 entries queued
      do_reset();
      tlast_interval = 0;
      M_AXIS_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         write_enable = 1'b1;
         data_pkt = rnd_data();
         tick();
      end
      write_enable = 1'b0;
      tick();
      chk("s6_queued", M_AXIS_tvalid, 1'b1);
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("s6_valid_in_reset", M_AXIS_tvalid, 1'b0);
      chk("s6_data_in_reset", M_AXIS_tdata, '0);
      tick();
      rst_n = 1'b1;
      M_AXIS_tready = 1'b1;
      xfer_d.delete();
      xfer_l.delete();
      for (int c = 0; c < 4; c++) tick();
      chk("s6_no_stale", DW'(xfer_d.size()), DW'(0));
      write_enable = 1'b1;
      data_pkt = rnd_data();
      tick();
      write_enable = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      chk("s6_accept_after", DW'(xfer_d.size()), DW'(1));

      // Random phase
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 0) tlast_interval = $urandom_range(0, 5);
         write_enable  = ($urandom_range(0, 3) != 0);
         tlast         = ($urandom_range(0, 7) == 0);
         M_AXIS_tready = ($urandom_range(0, 2) != 0);
         data_pkt      = rnd_data();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
